// File: rtl/router_pkt_tx.sv
// Packet framer for the 1x3 router input port: buffers payload bytes, then sends
// header {len,addr}, len payload bytes and an XOR parity byte under busy flow control.
module router_pkt_tx #(
  parameter int BUF_DEPTH = 64,
  parameter int GAP_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buf_wr_en,
  input  logic [7:0] buf_wr_data,
  output logic       buf_full,
  output logic [6:0] buf_count,
  input  logic       tx_start,
  input  logic [1:0] tx_addr,
  input  logic [5:0] tx_len,
  input  logic       tx_corrupt_parity,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_in,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int         AW      = $clog2(BUF_DEPTH);
  localparam logic [6:0] DEPTH_C = 7'(BUF_DEPTH);
  localparam logic [7:0] GAP_LD  = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [BUF_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [6:0]    r_count;
  logic          r_buf_full;
  logic          r_pkt_valid;
  logic [7:0]    r_data_in;
  logic          r_tx_active;
  logic          r_tx_done;
  logic          r_tx_err;
  logic [7:0]    r_parity;
  logic [5:0]    r_remaining;
  logic          r_corrupt;
  logic [7:0]    r_gap;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_rd_nxt;
  logic [6:0]    w_count_nxt;
  logic          w_start_ok;
  logic [7:0]    w_header;
  logic [7:0]    w_par_final;

  assign w_push      = buf_wr_en && !r_buf_full;
  assign w_pop       = (r_state == S_PAYLOAD) && !busy;
  assign w_rd_nxt    = r_rd_ptr + 1'b1;
  assign w_start_ok  = (tx_addr != 2'd3) && (tx_len != 6'd0) && (r_count >= {1'b0, tx_len});
  assign w_header    = {tx_len, tx_addr};
  // The last payload byte is still on data_in when the parity byte is formed.
  assign w_par_final = (r_parity ^ r_data_in) ^ {8{r_corrupt}};

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 7'd1;
      2'b01:   w_count_nxt = r_count - 7'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: payload storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= buf_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_buf_full <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_count    <= w_count_nxt;
      r_buf_full <= (w_count_nxt == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pkt_valid <= 1'b0;
      r_data_in   <= '0;
      r_tx_active <= 1'b0;
      r_tx_done   <= 1'b0;
      r_tx_err    <= 1'b0;
      r_parity    <= '0;
      r_remaining <= '0;
      r_corrupt   <= 1'b0;
      r_gap       <= '0;
    end else begin
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            if (w_start_ok) begin
              r_state     <= S_HEADER;
              r_pkt_valid <= 1'b1;
              r_data_in   <= w_header;
              r_parity    <= w_header;
              r_remaining <= tx_len;
              r_corrupt   <= tx_corrupt_parity;
              r_tx_active <= 1'b1;
            end else begin
              r_tx_err <= 1'b1;
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            r_state   <= S_PAYLOAD;
            r_data_in <= r_mem[r_rd_ptr];
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            r_parity    <= r_parity ^ r_data_in;
            r_remaining <= r_remaining - 6'd1;
            if (r_remaining == 6'd1) begin
              r_state     <= S_PARITY;
              r_pkt_valid <= 1'b0;
              r_data_in   <= w_par_final;
            end else begin
              // Show the byte behind the one being popped this edge.
              r_data_in <= r_mem[w_rd_nxt];
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            r_state   <= S_GAP;
            r_data_in <= '0;
            r_tx_done <= 1'b1;
            r_gap     <= GAP_LD;
          end
        end
        S_GAP: begin
          if (r_gap == 8'd0) begin
            r_state     <= S_IDLE;
            r_tx_active <= 1'b0;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign buf_full  = r_buf_full;
  assign buf_count = r_count;
  assign pkt_valid = r_pkt_valid;
  assign data_in   = r_data_in;
  assign tx_active = r_tx_active;
  assign tx_done   = r_tx_done;
  assign tx_err    = r_tx_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: framing, busy hold, rejects, corrupt parity,
// buffer full and mid-packet reset, all against hand-computed values.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       buf_wr_en;
  logic [7:0] buf_wr_data;
  logic       buf_full;
  logic [6:0] buf_count;
  logic       tx_start;
  logic [1:0] tx_addr;
  logic [5:0] tx_len;
  logic       tx_corrupt_parity;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       tx_active;
  logic       tx_done;
  logic       tx_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap [80];
  int         n_cap;
  logic [7:0] par;
  int         done_cnt;
  int         hold_err;

  router_pkt_tx #(.BUF_DEPTH(64), .GAP_CYC(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .buf_wr_en         (buf_wr_en),
    .buf_wr_data       (buf_wr_data),
    .buf_full          (buf_full),
    .buf_count         (buf_count),
    .tx_start          (tx_start),
    .tx_addr           (tx_addr),
    .tx_len            (tx_len),
    .tx_corrupt_parity (tx_corrupt_parity),
    .busy              (busy),
    .pkt_valid         (pkt_valid),
    .data_in           (data_in),
    .tx_active         (tx_active),
    .tx_done           (tx_done),
    .tx_err            (tx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    buf_wr_en   = 1'b1;
    buf_wr_data = b;
    tick();
    buf_wr_en   = 1'b0;
  endtask

  task automatic start(input logic [1:0] a, input logic [5:0] l, input logic c);
    tx_addr           = a;
    tx_len            = l;
    tx_corrupt_parity = c;
    tx_start          = 1'b1;
    tick();
    tx_start          = 1'b0;
    tx_corrupt_parity = 1'b0;
  endtask

  // Drives busy from busy_pat (bit c = cycle c after the header appears) and records
  // every transferred byte plus the parity byte until tx_active drops.
  task automatic run_pkt(input logic [63:0] busy_pat);
    logic       finished = 1'b0;
    logic       par_seen = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] prev_data = '0;
    n_cap = 0; done_cnt = 0; hold_err = 0; par = '0;
    for (int c = 0; c < 200 && !finished; c++) begin
      busy = (c < 64) ? busy_pat[c] : 1'b0;
      if (tx_done) done_cnt++;
      if (!tx_active) finished = 1'b1;
      else begin
        if (prev_busy && pkt_valid && data_in !== prev_data) hold_err++;
        if (!busy) begin
          if (pkt_valid) begin
            cap[n_cap] = data_in;
            n_cap++;
          end else if (n_cap > 0 && !par_seen) begin
            par      = data_in;
            par_seen = 1'b1;
          end
        end
        prev_busy = busy;
        prev_data = data_in;
        tick();
      end
    end
    busy = 1'b0;
    if (!finished) check("pkt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; buf_wr_en = 1'b0; buf_wr_data = '0; tx_start = 1'b0;
    tx_addr = '0; tx_len = '0; tx_corrupt_parity = 1'b0; busy = 1'b0;
    tick(); tick();
    check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check("rst_data_in",   32'(data_in),   32'd0);
    check("rst_tx_active", 32'(tx_active), 32'd0);
    check("rst_tx_done",   32'(tx_done),   32'd0);
    check("rst_tx_err",    32'(tx_err),    32'd0);
    check("rst_buf_count", 32'(buf_count), 32'd0);
    reset = 1'b0;
    tick();

    // T1: basic packet, no backpressure
    push(8'h11); push(8'h22); push(8'h33);
    check("t1_count", 32'(buf_count), 32'd3);
    start(2'd1, 6'd3, 1'b0);
    check("t1_hdr_valid",  32'(pkt_valid), 32'd1);
    check("t1_hdr_data",   32'(data_in),   32'h0D);
    check("t1_active",     32'(tx_active), 32'd1);
    run_pkt(64'h0);
    check("t1_nbytes", 32'(n_cap), 32'd4);
    check("t1_b0", 32'(cap[0]), 32'h0D);
    check("t1_b1", 32'(cap[1]), 32'h11);
    check("t1_b2", 32'(cap[2]), 32'h22);
    check("t1_b3", 32'(cap[3]), 32'h33);
    check("t1_parity", 32'(par), 32'h0D);
    check("t1_done",   32'(done_cnt), 32'd1);
    check("t1_count_after", 32'(buf_count), 32'd0);

    // T2: busy for 3 cycles while byte 22 is shown
    push(8'h11); push(8'h22); push(8'h33);
    start(2'd1, 6'd3, 1'b0);
    run_pkt(64'h1C);
    check("t2_nbytes", 32'(n_cap), 32'd4);
    check("t2_b1", 32'(cap[1]), 32'h11);
    check("t2_b2", 32'(cap[2]), 32'h22);
    check("t2_b3", 32'(cap[3]), 32'h33);
    check("t2_parity", 32'(par), 32'h0D);
    check("t2_hold",   32'(hold_err), 32'd0);
    check("t2_done",   32'(done_cnt), 32'd1);

    // T3: rejected requests, then drain the two bytes with a legal packet
    push(8'h5A); push(8'hC3);
    start(2'd3, 6'd1, 1'b0);
    check("t3a_err", 32'(tx_err), 32'd1);
    check("t3a_pv",  32'(pkt_valid), 32'd0);
    tick();
    check("t3a_err_pulse", 32'(tx_err), 32'd0);
    start(2'd0, 6'd0, 1'b0);
    check("t3b_err", 32'(tx_err), 32'd1);
    check("t3b_active", 32'(tx_active), 32'd0);
    tick();
    start(2'd0, 6'd5, 1'b0);
    check("t3c_err", 32'(tx_err), 32'd1);
    check("t3c_pv",  32'(pkt_valid), 32'd0);
    check("t3_count", 32'(buf_count), 32'd2);
    tick();
    start(2'd0, 6'd2, 1'b0);
    run_pkt(64'h0);
    check("t3d_hdr",    32'(cap[0]), 32'h08);
    check("t3d_b1",     32'(cap[1]), 32'h5A);
    check("t3d_b2",     32'(cap[2]), 32'hC3);
    check("t3d_parity", 32'(par),    32'h91);

    // T4: corrupted parity
    push(8'hAA);
    start(2'd2, 6'd1, 1'b1);
    run_pkt(64'h0);
    check("t4_nbytes", 32'(n_cap), 32'd2);
    check("t4_hdr",    32'(cap[0]), 32'h06);
    check("t4_b1",     32'(cap[1]), 32'hAA);
    check("t4_parity", 32'(par),    32'h53);

    // T5: fill past capacity, then a maximum-length packet
    for (int i = 0; i < 63; i++) push(8'(i));
    check("t5_not_full", 32'(buf_full), 32'd0);
    push(8'd63);
    check("t5_full",  32'(buf_full),  32'd1);
    check("t5_count", 32'(buf_count), 32'd64);
    push(8'd64);
    check("t5_drop_count", 32'(buf_count), 32'd64);
    start(2'd0, 6'd63, 1'b0);
    run_pkt(64'h0);
    check("t5_nbytes", 32'(n_cap), 32'd64);
    check("t5_hdr",    32'(cap[0]),  32'hFC);
    check("t5_first",  32'(cap[1]),  32'h00);
    check("t5_last",   32'(cap[63]), 32'h3E);
    check("t5_parity", 32'(par),     32'hC3);
    check("t5_count_after", 32'(buf_count), 32'd1);
    check("t5_not_full_after", 32'(buf_full), 32'd0);

    // T6: reset in the middle of the payload
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    start(2'd1, 6'd5, 1'b0);
    tick(); tick();
    check("t6_mid_pv", 32'(pkt_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_pv",     32'(pkt_valid), 32'd0);
    check("t6_data",   32'(data_in),   32'd0);
    check("t6_count",  32'(buf_count), 32'd0);
    check("t6_active", 32'(tx_active), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (tx_done) done_cnt++;
      tick();
    end
    check("t6_no_done", 32'(done_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
